// File: rtl/aes128_pio_engine.sv
// aes128_pio_engine: iterative AES-128 encryptor behind the HPS PIO map.
// One cycle of key whitening then one round per cycle, round keys derived on the fly.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] s_o
);
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      p = b[k] ? p ^ x : p;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] inv;
  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box requires
  always_comb begin
    logic [7:0] p;
    p = a_i;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      inv = gmul(inv, p);
    end
  end
  assign s_o = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

module aes128_pio_engine (
  input  logic        clk,
  input  logic        reset,
  input  logic        sw_reset,
  input  logic        enable,
  input  logic [31:0] plaintext0,
  input  logic [31:0] plaintext1,
  input  logic [31:0] plaintext2,
  input  logic [31:0] plaintext3,
  input  logic [7:0]  key0,
  input  logic [7:0]  key1,
  input  logic [7:0]  key2,
  input  logic [7:0]  key3,
  input  logic [7:0]  key4,
  input  logic [7:0]  key5,
  input  logic [7:0]  key6,
  input  logic [7:0]  key7,
  input  logic [7:0]  key8,
  input  logic [7:0]  key9,
  input  logic [7:0]  key10,
  input  logic [7:0]  key11,
  input  logic [7:0]  key12,
  input  logic [7:0]  key13,
  input  logic [7:0]  key14,
  input  logic [7:0]  key15,
  output logic [31:0] ciphertext0,
  output logic [31:0] ciphertext1,
  output logic [31:0] ciphertext2,
  output logic [31:0] ciphertext3,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  fsm_t         fsm_q;
  logic         enable_q, busy_q, done_q;
  logic [3:0]   rnd_q;
  logic [127:0] state_q, rkey_q, ct_q;
  logic [127:0] pt, key, sr, mc, nk, round_d;
  logic [7:0]   sb [16];
  logic [7:0]   rcon;
  logic [31:0]  rot, sw, t, n0, n1, n2, n3;
  assign pt  = {plaintext0, plaintext1, plaintext2, plaintext3};
  assign key = {key0, key1, key2, key3, key4, key5, key6, key7,
                key8, key9, key10, key11, key12, key13, key14, key15};
  // byte i sits at row i%4, column i/4; ShiftRows pulls row r from column c+r
  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sb (.a_i(state_q[127-8*i -: 8]), .s_o(sb[i]));
    assign sr[127-8*i -: 8] = sb[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
  end
  for (genvar c = 0; c < 4; c++) begin : g_mix
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = sr[127-32*c -: 32];
    assign mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end
  assign rot = {rkey_q[23:0], rkey_q[31:24]};
  for (genvar j = 0; j < 4; j++) begin : g_ks
    aes_sbox u_ks (.a_i(rot[31-8*j -: 8]), .s_o(sw[31-8*j -: 8]));
  end
  assign rcon    = (rnd_q <= 4'd8) ? (8'h01 << (rnd_q - 4'd1)) : (rnd_q == 4'd9) ? 8'h1b : 8'h36;
  assign t       = sw ^ {rcon, 24'h000000};
  assign n0      = rkey_q[127:96] ^ t;
  assign n1      = rkey_q[95:64] ^ n0;
  assign n2      = rkey_q[63:32] ^ n1;
  assign n3      = rkey_q[31:0] ^ n2;
  assign nk      = {n0, n1, n2, n3};
  assign round_d = ((rnd_q == 4'd10) ? sr : mc) ^ nk;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q    <= IDLE;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rnd_q    <= 4'd0;
      state_q  <= '0;
      rkey_q   <= '0;
      ct_q     <= '0;
    end else begin
      enable_q <= enable;
      if (sw_reset) begin
        fsm_q   <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        rnd_q   <= 4'd0;
        state_q <= '0;
        rkey_q  <= '0;
        ct_q    <= '0;
      end else if (fsm_q == ROUND) begin
        state_q <= round_d;
        rkey_q  <= nk;
        rnd_q   <= rnd_q + 4'd1;
        if (rnd_q == 4'd10) begin
          ct_q   <= round_d;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          fsm_q  <= DONE;
        end
      end else if (enable & ~enable_q) begin
        state_q <= pt ^ key;
        rkey_q  <= key;
        rnd_q   <= 4'd1;
        done_q  <= 1'b0;
        busy_q  <= 1'b1;
        fsm_q   <= ROUND;
      end
    end
  end
  assign {ciphertext0, ciphertext1, ciphertext2, ciphertext3} = ct_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_aes128_pio_engine.sv
// tb_aes128_pio_engine: directed FIPS-197 vectors against a cycle-level reference model
// of the PIO protocol whose AES core is built from first-principles field arithmetic.
module tb_aes128_pio_engine;
  logic clk = 1'b0, reset = 1'b0, sw_reset = 1'b0, enable = 1'b0;
  logic [31:0] plaintext0 = '0, plaintext1 = '0, plaintext2 = '0, plaintext3 = '0;
  logic [7:0] key0 = '0, key1 = '0, key2 = '0, key3 = '0, key4 = '0, key5 = '0, key6 = '0, key7 = '0;
  logic [7:0] key8 = '0, key9 = '0, key10 = '0, key11 = '0, key12 = '0, key13 = '0, key14 = '0, key15 = '0;
  logic [31:0] ciphertext0, ciphertext1, ciphertext2, ciphertext3;
  logic busy, done;
  int n_tests = 0, n_fail = 0;
  logic [7:0] sb_t [256];

  aes128_pio_engine dut (
    .clk(clk), .reset(reset), .sw_reset(sw_reset), .enable(enable),
    .plaintext0(plaintext0), .plaintext1(plaintext1), .plaintext2(plaintext2), .plaintext3(plaintext3),
    .key0(key0), .key1(key1), .key2(key2), .key3(key3), .key4(key4), .key5(key5), .key6(key6), .key7(key7),
    .key8(key8), .key9(key9), .key10(key10), .key11(key11), .key12(key12), .key13(key13), .key14(key14),
    .key15(key15),
    .ciphertext0(ciphertext0), .ciphertext1(ciphertext1), .ciphertext2(ciphertext2), .ciphertext3(ciphertext3),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] w [44];
    logic [31:0] x;
    logic [7:0] rc;
    logic [127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      x = w[i-1];
      if (i % 4 == 0) begin
        x = {sb_t[x[23:16]], sb_t[x[15:8]], sb_t[x[7:0]], sb_t[x[31:24]]} ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end
      w[i] = w[i-4] ^ x;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rn = 1; rn <= 10; rn++) begin
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = sb_t[s[rr+4*((c+rr)%4)]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++)
          s[4*c+rr] = (rn == 10) ? t[4*c+rr] :
                      gm(8'h02, t[4*c+rr]) ^ gm(8'h03, t[4*c+(rr+1)%4]) ^ t[4*c+(rr+2)%4] ^ t[4*c+(rr+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rn + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
    return r;
  endfunction

  // protocol model: a start edge schedules the result to appear ten clocks later
  logic m_en_q, m_done;
  int m_left;
  logic [127:0] m_ct, m_res;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en_q <= 1'b0; m_done <= 1'b0; m_left <= 0; m_ct <= '0; m_res <= '0;
    end else begin
      m_en_q <= enable;
      if (sw_reset) begin
        m_left <= 0; m_done <= 1'b0; m_ct <= '0;
      end else if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_ct <= m_res; m_done <= 1'b1;
        end
      end else if (enable && !m_en_q) begin
        m_res <= aes_enc({plaintext0, plaintext1, plaintext2, plaintext3},
                         {key0, key1, key2, key3, key4, key5, key6, key7,
                          key8, key9, key10, key11, key12, key13, key14, key15});
        m_left <= 10; m_done <= 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #2;
    n_tests++;
    if (busy !== (m_left != 0) || done !== m_done ||
        {ciphertext0, ciphertext1, ciphertext2, ciphertext3} !== m_ct) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t: busy=%b done=%b ct=%h expected busy=%b done=%b ct=%h",
               $time, busy, done, {ciphertext0, ciphertext1, ciphertext2, ciphertext3},
               m_left != 0, m_done, m_ct);
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input logic [127:0] pt, input logic [127:0] k);
    {plaintext0, plaintext1, plaintext2, plaintext3} = pt;
    {key0, key1, key2, key3, key4, key5, key6, key7,
     key8, key9, key10, key11, key12, key13, key14, key15} = k;
  endtask

  // call just after a negedge with enable low; meddle scrambles inputs mid-run
  task automatic run(input string nm, input logic [127:0] pt, input logic [127:0] k,
                     input logic [127:0] exp, input bit hold, input bit meddle);
    int lat, nb;
    chk({nm, "_model"}, aes_enc(pt, k), exp);
    set_vec(pt, k);
    enable = 1'b1;
    lat = 0; nb = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        if (!hold) enable = 1'b0;
        chk({nm, "_done_drop"}, 128'(done), 128'd0);
      end
      if (meddle && c == 3) set_vec(~pt, ~k);
      if (meddle && c == 4) enable = 1'b1;
      if (meddle && c == 6) enable = 1'b0;
      if (busy) nb++;
      if (done) begin lat = c; break; end
    end
    chk({nm, "_latency"}, 128'(lat), 128'd11);
    chk({nm, "_busy_cycles"}, 128'(nb), 128'd10);
    chk({nm, "_ct"}, {ciphertext0, ciphertext1, ciphertext2, ciphertext3}, exp);
  endtask

  localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  initial begin
    logic [7:0] inv, s, cst;
    int cnt;
    cst = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ cst[i];
      sb_t[x] = s;
    end
    #1 reset = 1'b1;
    #1 chk("reset_state", {127'(busy), done}, 128'd0);
    chk("reset_ct", {ciphertext0, ciphertext1, ciphertext2, ciphertext3}, 128'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run("appB", PB, KB, CB, 1'b0, 1'b0);
    run("appC1", PC, KC, CC, 1'b0, 1'b0);
    run("zero", '0, '0, CZ, 1'b0, 1'b0);
    run("restartB", PB, KB, CB, 1'b0, 1'b0);
    run("stable", PC, KC, CC, 1'b0, 1'b1);
    repeat (15) @(negedge clk);
    chk("stable_no_rerun", {ciphertext0, ciphertext1, ciphertext2, ciphertext3, 126'd0} >> 0 == {CC, 126'd0} ? 128'(done) : 128'd0, 128'd1);
    run("hold", PB, KB, CB, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    chk("hold_done", {126'd0, busy, done}, 128'd1);
    enable = 1'b0;
    @(negedge clk);
    set_vec(PC, KC);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("async_abort", {127'(busy), done}, 128'd0);
    chk("async_ct", {ciphertext0, ciphertext1, ciphertext2, ciphertext3}, 128'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run("after_reset", PB, KB, CB, 1'b0, 1'b0);
    set_vec(PC, KC);
    enable = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) enable = 1'b0;
      if (c == 5) sw_reset = 1'b1;
    end
    @(negedge clk);
    sw_reset = 1'b0;
    chk("swr_state", {127'(busy), done}, 128'd0);
    chk("swr_ct", {ciphertext0, ciphertext1, ciphertext2, ciphertext3}, 128'd0);
    cnt = 0;
    repeat (15) begin @(negedge clk); if (done) cnt++; end
    chk("swr_no_done", 128'(cnt), 128'd0);
    sw_reset = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    sw_reset = 1'b0;
    cnt = 0;
    repeat (15) begin @(negedge clk); if (busy || done) cnt++; end
    chk("swr_edge_consumed", 128'(cnt), 128'd0);
    enable = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
